// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: transfer descriptor, channel widths and the arbiter FSM state.
package hyperbus_pkg;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned StrbWidth = 2;

  typedef struct packed {
    logic [31:0] address;
    logic        write;
    logic        address_space;
    logic        burst_type;
    logic [15:0] burst;
  } hyper_tf_t;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Offer = 2'd1,
    Busy  = 2'd2
  } hyper_arb_state_t;

endpackage

// File: rtl/hyperbus_rr_sel.sv
// Combinational round-robin search: first set request at or after rr_ptr, wrapping at NumReq.
module hyperbus_rr_sel #(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned IdxWidth = 1
) (
  input  logic [NumReq-1:0]   req_mask,
  input  logic [IdxWidth-1:0] rr_ptr,
  output logic [IdxWidth-1:0] sel,
  output logic                any_valid
);

  localparam int unsigned CandWidth = IdxWidth + 1;

  logic [CandWidth-1:0] cand;

  // One extra bit on the candidate so NumReq that is not a power of two wraps by comparison.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = CandWidth'(rr_ptr) + CandWidth'(i);
      if (cand >= CandWidth'(NumReq)) begin
        cand = cand - CandWidth'(NumReq);
      end
      if (!any_valid && req_mask[cand[IdxWidth-1:0]]) begin
        sel       = cand[IdxWidth-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyperbus_trans_arb.sv
// Round-robin arbiter granting one requester at a time exclusive use of a HyperBus PHY.
module hyperbus_trans_arb
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned NumChips = 2,
  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_trans_valid_i,
  output logic [NumReq-1:0]    req_trans_ready_o,
  input  hyper_tf_t            req_trans_i    [NumReq],
  input  logic [NumChips-1:0]  req_trans_cs_i [NumReq],
  input  logic [NumReq-1:0]    req_tx_valid_i,
  output logic [NumReq-1:0]    req_tx_ready_o,
  input  logic [DataWidth-1:0] req_tx_data_i  [NumReq],
  input  logic [StrbWidth-1:0] req_tx_strb_i  [NumReq],
  input  logic [NumReq-1:0]    req_tx_last_i,
  output logic [NumReq-1:0]    req_rx_valid_o,
  input  logic [NumReq-1:0]    req_rx_ready_i,
  output logic [DataWidth-1:0] req_rx_data_o  [NumReq],
  output logic [NumReq-1:0]    req_rx_error_o,
  output logic [NumReq-1:0]    req_rx_last_o,
  output logic [NumReq-1:0]    req_b_valid_o,
  output logic [NumReq-1:0]    req_b_error_o,
  input  logic [NumReq-1:0]    req_b_ready_i,
  output logic                 phy_trans_valid_o,
  input  logic                 phy_trans_ready_i,
  output hyper_tf_t            phy_trans_o,
  output logic [NumChips-1:0]  phy_trans_cs_o,
  output logic                 phy_tx_valid_o,
  input  logic                 phy_tx_ready_i,
  output logic [DataWidth-1:0] phy_tx_data_o,
  output logic [StrbWidth-1:0] phy_tx_strb_o,
  output logic                 phy_tx_last_o,
  input  logic                 phy_rx_valid_i,
  output logic                 phy_rx_ready_o,
  input  logic [DataWidth-1:0] phy_rx_data_i,
  input  logic                 phy_rx_error_i,
  input  logic                 phy_rx_last_i,
  input  logic                 phy_b_valid_i,
  output logic                 phy_b_ready_o,
  input  logic                 phy_b_error_i,
  output logic [IdxWidth-1:0]  owner_o,
  output logic                 busy_o,
  output logic                 sticky_err_o
);

  hyper_arb_state_t    state_q, state_d;
  logic [IdxWidth-1:0] owner_q, owner_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic                is_write_q, is_write_d;
  logic                sticky_err_q, sticky_err_d;

  logic [IdxWidth-1:0] sel;
  logic                any_valid;
  logic [IdxWidth-1:0] offer_idx;
  logic                offer_en;
  logic                done;

  hyperbus_rr_sel #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_rr_sel (
    .req_mask  (req_trans_valid_i),
    .rr_ptr    (rr_ptr_q),
    .sel       (sel),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= Idle;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      is_write_q   <= 1'b0;
      sticky_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      is_write_q   <= is_write_d;
      sticky_err_q <= sticky_err_d;
    end
  end

  // Offer lock: once an index is presented, only that descriptor is shown until accepted.
  assign offer_idx = (state_q == Offer) ? owner_q : sel;
  assign offer_en  = rst_ni && ((state_q == Offer) || ((state_q == Idle) && any_valid));
  assign done      = is_write_q ? (phy_b_valid_i && req_b_ready_i[owner_q])
                                : (phy_rx_valid_i && phy_rx_last_i && req_rx_ready_i[owner_q]);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    is_write_d   = is_write_q;
    sticky_err_d = sticky_err_q;

    req_trans_ready_o = '0;
    phy_trans_valid_o = 1'b0;
    phy_trans_o       = '0;
    phy_trans_cs_o    = '0;
    req_tx_ready_o    = '0;
    phy_tx_valid_o    = 1'b0;
    phy_tx_data_o     = '0;
    phy_tx_strb_o     = '0;
    phy_tx_last_o     = 1'b0;
    req_rx_valid_o    = '0;
    req_rx_error_o    = '0;
    req_rx_last_o     = '0;
    phy_rx_ready_o    = 1'b0;
    req_b_valid_o     = '0;
    req_b_error_o     = '0;
    phy_b_ready_o     = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_rx_data_o[i] = '0;
    end

    if (offer_en) begin
      phy_trans_valid_o = 1'b1;
      phy_trans_o       = req_trans_i[offer_idx];
      phy_trans_cs_o    = req_trans_cs_i[offer_idx];
      if (phy_trans_ready_i) begin
        req_trans_ready_o[offer_idx] = 1'b1;
        is_write_d                   = req_trans_i[offer_idx].write;
      end
    end

    unique case (state_q)
      Idle, Offer: begin
        // Stray responses with no owner are swallowed and remembered.
        phy_rx_ready_o = rst_ni;
        phy_b_ready_o  = rst_ni;
        if (phy_rx_valid_i || phy_b_valid_i) begin
          sticky_err_d = 1'b1;
        end
        if (offer_en) begin
          owner_d = offer_idx;
          state_d = phy_trans_ready_i ? Busy : Offer;
        end
      end
      Busy: begin
        phy_tx_valid_o          = req_tx_valid_i[owner_q];
        phy_tx_data_o           = req_tx_data_i[owner_q];
        phy_tx_strb_o           = req_tx_strb_i[owner_q];
        phy_tx_last_o           = req_tx_last_i[owner_q];
        req_tx_ready_o[owner_q] = phy_tx_ready_i;
        req_rx_valid_o[owner_q] = phy_rx_valid_i;
        req_rx_data_o[owner_q]  = phy_rx_data_i;
        req_rx_error_o[owner_q] = phy_rx_error_i;
        req_rx_last_o[owner_q]  = phy_rx_last_i;
        phy_rx_ready_o          = req_rx_ready_i[owner_q];
        req_b_valid_o[owner_q]  = phy_b_valid_i;
        req_b_error_o[owner_q]  = phy_b_error_i;
        phy_b_ready_o           = req_b_ready_i[owner_q];
        if (done) begin
          state_d  = Idle;
          rr_ptr_d = (owner_q == IdxWidth'(NumReq - 1)) ? '0 : owner_q + IdxWidth'(1);
        end
      end
      default: state_d = Idle;
    endcase
  end

  assign owner_o      = owner_q;
  assign busy_o       = (state_q != Idle);
  assign sticky_err_o = sticky_err_q;

endmodule

// File: tb/tb_hyperbus_trans_arb.sv
// Directed plus randomized bench for hyperbus_trans_arb with a round-robin reference model.
module tb_hyperbus_trans_arb;
  import hyperbus_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned C  = 2;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_trans_valid, req_trans_ready;
  hyper_tf_t       req_trans    [N];
  logic [C-1:0]    req_trans_cs [N];
  logic [N-1:0]    req_tx_valid, req_tx_ready, req_tx_last;
  logic [15:0]     req_tx_data  [N];
  logic [1:0]      req_tx_strb  [N];
  logic [N-1:0]    req_rx_valid, req_rx_ready, req_rx_error, req_rx_last;
  logic [15:0]     req_rx_data  [N];
  logic [N-1:0]    req_b_valid, req_b_error, req_b_ready;
  logic            phy_trans_valid, phy_trans_ready;
  hyper_tf_t       phy_trans;
  logic [C-1:0]    phy_trans_cs;
  logic            phy_tx_valid, phy_tx_ready, phy_tx_last;
  logic [15:0]     phy_tx_data;
  logic [1:0]      phy_tx_strb;
  logic            phy_rx_valid, phy_rx_ready, phy_rx_error, phy_rx_last;
  logic [15:0]     phy_rx_data;
  logic            phy_b_valid, phy_b_ready, phy_b_error;
  logic [IW-1:0]   owner;
  logic            busy, sticky_err;

  hyperbus_trans_arb #(.NumReq(N), .NumChips(C)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_trans_valid_i(req_trans_valid), .req_trans_ready_o(req_trans_ready),
    .req_trans_i(req_trans), .req_trans_cs_i(req_trans_cs),
    .req_tx_valid_i(req_tx_valid), .req_tx_ready_o(req_tx_ready), .req_tx_data_i(req_tx_data),
    .req_tx_strb_i(req_tx_strb), .req_tx_last_i(req_tx_last),
    .req_rx_valid_o(req_rx_valid), .req_rx_ready_i(req_rx_ready), .req_rx_data_o(req_rx_data),
    .req_rx_error_o(req_rx_error), .req_rx_last_o(req_rx_last),
    .req_b_valid_o(req_b_valid), .req_b_error_o(req_b_error), .req_b_ready_i(req_b_ready),
    .phy_trans_valid_o(phy_trans_valid), .phy_trans_ready_i(phy_trans_ready),
    .phy_trans_o(phy_trans), .phy_trans_cs_o(phy_trans_cs),
    .phy_tx_valid_o(phy_tx_valid), .phy_tx_ready_i(phy_tx_ready), .phy_tx_data_o(phy_tx_data),
    .phy_tx_strb_o(phy_tx_strb), .phy_tx_last_o(phy_tx_last),
    .phy_rx_valid_i(phy_rx_valid), .phy_rx_ready_o(phy_rx_ready), .phy_rx_data_i(phy_rx_data),
    .phy_rx_error_i(phy_rx_error), .phy_rx_last_i(phy_rx_last),
    .phy_b_valid_i(phy_b_valid), .phy_b_ready_o(phy_b_ready), .phy_b_error_i(phy_b_error),
    .owner_o(owner), .busy_o(busy), .sticky_err_o(sticky_err)
  );

  int total = 0;
  int bad   = 0;
  int ptr   = 0;  // model: where the next round-robin search starts

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (mask[c]) return c;
    end
    return 0;
  endfunction

  function automatic hyper_tf_t rand_desc(input int wr);
    hyper_tf_t d;
    d.address       = $urandom;
    d.write         = 1'($urandom_range(0, 1));
    d.address_space = 1'($urandom_range(0, 1));
    d.burst_type    = 1'($urandom_range(0, 1));
    d.burst         = 16'($urandom);
    if (wr >= 0) d.write = wr[0];
    return d;
  endfunction

  task automatic clear_inputs();
    req_trans_valid = '0; req_tx_valid = '0; req_tx_last = '0;
    req_rx_ready = '0; req_b_ready = '0;
    phy_trans_ready = 1'b0; phy_tx_ready = 1'b0;
    phy_rx_valid = 1'b0; phy_rx_error = 1'b0; phy_rx_last = 1'b0; phy_rx_data = '0;
    phy_b_valid = 1'b0; phy_b_error = 1'b0;
    for (int r = 0; r < N; r++) begin
      req_trans[r] = '0; req_trans_cs[r] = '0; req_tx_data[r] = '0; req_tx_strb[r] = '0;
    end
  endtask

  // Present mask, hold PHY off for delay cycles (mask replaced by mid_mask from the 2nd), then accept.
  task automatic grant(input logic [N-1:0] mask, input logic [N-1:0] mid_mask, input int delay,
                       input int wr, input bit keep, output int win);
    win = pick(mask);
    for (int r = 0; r < N; r++) begin
      req_trans[r]    = rand_desc(wr);
      req_trans_cs[r] = 2'($urandom);
    end
    req_trans_valid = mask;
    phy_trans_ready = 1'b0;
    for (int c = 0; c < delay; c++) begin
      if (c == 1) req_trans_valid = mid_mask;
      #1;
      chk("offer_valid", 64'(phy_trans_valid), 64'd1);
      chk("offer_desc", 64'(phy_trans), 64'(req_trans[win]));
      chk("offer_ready", 64'(req_trans_ready), 64'd0);
      step();
    end
    phy_trans_ready = 1'b1;
    #1;
    chk("accept_ready", 64'(req_trans_ready), 64'(oh(win)));
    chk("accept_desc", 64'(phy_trans), 64'(req_trans[win]));
    chk("accept_cs", 64'(phy_trans_cs), 64'(req_trans_cs[win]));
    step();
    phy_trans_ready = 1'b0;
    if (!keep) req_trans_valid[win] = 1'b0;
    #1;
    chk("busy_after_grant", 64'(busy), 64'd1);
    chk("owner_after_grant", 64'(owner), 64'(win));
    chk("busy_trans_valid", 64'(phy_trans_valid), 64'd0);
    chk("busy_trans_ready", 64'(req_trans_ready), 64'd0);
  endtask

  task automatic run_write(input int own, input int beats);
    logic err;
    for (int b = 0; b < beats; b++) begin
      for (int r = 0; r < N; r++) begin
        req_tx_valid[r] = 1'b1;
        req_tx_data[r]  = 16'($urandom);
        req_tx_strb[r]  = 2'($urandom);
        req_tx_last[r]  = (b == beats - 1);
      end
      phy_tx_ready = 1'b1;
      #1;
      chk("tx_valid", 64'(phy_tx_valid), 64'd1);
      chk("tx_data", 64'(phy_tx_data), 64'(req_tx_data[own]));
      chk("tx_strb", 64'(phy_tx_strb), 64'(req_tx_strb[own]));
      chk("tx_last", 64'(phy_tx_last), 64'(b == beats - 1));
      chk("tx_ready_owner_only", 64'(req_tx_ready), 64'(oh(own)));
      chk("tx_no_rx", 64'(req_rx_valid), 64'd0);
      step();
    end
    req_tx_valid = '0; req_tx_last = '0; phy_tx_ready = 1'b0;
    err = 1'($urandom_range(0, 1));
    phy_b_valid = 1'b1; phy_b_error = err; req_b_ready = ~oh(own);
    #1;
    chk("b_stall_valid", 64'(req_b_valid), 64'(oh(own)));
    chk("b_stall_ready", 64'(phy_b_ready), 64'd0);
    step();
    chk("b_stall_busy", 64'(busy), 64'd1);
    req_b_ready = '1;
    #1;
    chk("b_valid_owner_only", 64'(req_b_valid), 64'(oh(own)));
    chk("b_error", 64'(req_b_error), err ? 64'(oh(own)) : 64'd0);
    chk("b_ready", 64'(phy_b_ready), 64'd1);
    chk("b_no_new_grant", 64'(req_trans_ready), 64'd0);
    chk("b_no_trans_valid", 64'(phy_trans_valid), 64'd0);
    step();
    phy_b_valid = 1'b0; phy_b_error = 1'b0; req_b_ready = '0;
    ptr = (own + 1) % N;
    #1;
    chk("idle_after_b", 64'(busy), 64'd0);
  endtask

  task automatic run_read(input int own, input int beats, input int stall);
    logic [15:0] others;
    for (int b = 0; b < beats; b++) begin
      phy_rx_valid = 1'b1;
      phy_rx_data  = 16'($urandom);
      phy_rx_last  = (b == beats - 1);
      phy_rx_error = 1'($urandom_range(0, 1));
      for (int s = 0; s < ((b == 0) ? stall : 0); s++) begin
        req_rx_ready = ~oh(own);
        #1;
        chk("rx_stall_valid", 64'(req_rx_valid), 64'(oh(own)));
        chk("rx_stall_ready", 64'(phy_rx_ready), 64'd0);
        step();
        chk("rx_stall_busy", 64'(busy), 64'd1);
      end
      req_rx_ready = '1;
      #1;
      others = '0;
      for (int r = 0; r < N; r++) if (r != own) others |= req_rx_data[r];
      chk("rx_valid_owner_only", 64'(req_rx_valid), 64'(oh(own)));
      chk("rx_data", 64'(req_rx_data[own]), 64'(phy_rx_data));
      chk("rx_data_others_zero", 64'(others), 64'd0);
      chk("rx_last", 64'(req_rx_last), phy_rx_last ? 64'(oh(own)) : 64'd0);
      chk("rx_error", 64'(req_rx_error), phy_rx_error ? 64'(oh(own)) : 64'd0);
      chk("rx_ready", 64'(phy_rx_ready), 64'd1);
      chk("rx_busy", 64'(busy), 64'd1);
      chk("rx_no_trans_valid", 64'(phy_trans_valid), 64'd0);
      step();
    end
    phy_rx_valid = 1'b0; phy_rx_last = 1'b0; phy_rx_error = 1'b0; req_rx_ready = '0;
    ptr = (own + 1) % N;
    #1;
    chk("idle_after_rx_last", 64'(busy), 64'd0);
  endtask

  initial begin
    int win;
    clear_inputs();
    rst_n = 1'b0;
    req_trans_valid = '1; phy_trans_ready = 1'b1; phy_rx_valid = 1'b1; phy_b_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trans_valid", 64'(phy_trans_valid), 64'd0);
    chk("rst_trans_ready", 64'(req_trans_ready), 64'd0);
    chk("rst_rx_ready", 64'(phy_rx_ready), 64'd0);
    chk("rst_b_ready", 64'(phy_b_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_sticky", 64'(sticky_err), 64'd0);
    clear_inputs();
    rst_n = 1'b1;
    step();

    // Simultaneous requests 0 and 1: 0 first, 1 the cycle after its B handshake.
    grant(3'b011, 3'b011, 0, 1, 1'b0, win);
    chk("first_owner_is_0", 64'(owner), 64'd0);
    run_write(0, 2);
    grant(req_trans_valid, req_trans_valid, 0, 1, 1'b0, win);
    chk("second_owner_is_1", 64'(owner), 64'd1);
    run_write(1, 1);

    // Lock in Offer against a later request, then a stalled 4-beat read.
    grant(3'b010, 3'b011, 3, 0, 1'b0, win);
    chk("locked_owner_is_1", 64'(owner), 64'd1);
    run_read(1, 4, 2);
    req_trans_valid = '0;

    // Requester drops valid while offered: the lock still holds.
    grant(3'b001, 3'b000, 2, 1, 1'b0, win);
    chk("dropped_owner_is_0", 64'(owner), 64'd0);
    run_write(0, 1);

    // Stray responses with no owner.
    req_trans_valid = '0;
    phy_b_valid = 1'b1;
    #1;
    chk("stray_b_ready", 64'(phy_b_ready), 64'd1);
    chk("stray_b_dropped", 64'(req_b_valid), 64'd0);
    chk("sticky_before", 64'(sticky_err), 64'd0);
    step();
    phy_b_valid = 1'b0; phy_rx_valid = 1'b1;
    #1;
    chk("sticky_after", 64'(sticky_err), 64'd1);
    chk("stray_rx_ready", 64'(phy_rx_ready), 64'd1);
    chk("stray_rx_dropped", 64'(req_rx_valid), 64'd0);
    step();
    phy_rx_valid = 1'b0;

    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, 7));
      grant(m, m | N'($urandom), int'($urandom_range(0, 3)), -1, 1'b0, win);
      if (req_trans[win].write) run_write(win, int'($urandom_range(1, 4)));
      else run_read(win, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
    end

    // Reset mid-transfer abandons it without a completion.
    grant('1, '1, 0, 1, 1'b1, win);
    phy_b_valid = 1'b1; req_b_ready = '1;
    rst_n = 1'b0;
    #1;
    chk("midrst_b_valid", 64'(req_b_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_trans_valid", 64'(phy_trans_valid), 64'd0);
    step();
    rst_n = 1'b1;
    req_trans_valid = '0; phy_b_valid = 1'b0; req_b_ready = '0;
    ptr = 0;
    #1;
    chk("postrst_busy", 64'(busy), 64'd0);
    chk("postrst_owner", 64'(owner), 64'd0);
    chk("postrst_trans_valid", 64'(phy_trans_valid), 64'd0);
    chk("postrst_tx_valid", 64'(phy_tx_valid), 64'd0);
    chk("postrst_rx_valid", 64'(req_rx_valid), 64'd0);
    chk("postrst_b_valid", 64'(req_b_valid), 64'd0);
    chk("postrst_sticky", 64'(sticky_err), 64'd0);

    // All three requesting continuously: 0,1,2,0.
    for (int k = 0; k < 4; k++) begin
      grant('1, '1, 0, 1, 1'b1, win);
      chk("rr_order", 64'(owner), 64'(k % 3));
      run_write(win, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hyperbus_trans_arb.md
HYPERBUS_TRANS_ARB -- requirements
Module: hyperbus_trans_arb

Interface
Parameters, one per line (name, default, meaning):
REQ-001 The block SHALL have parameter NumReq, default 2, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter NumChips, default 2, giving the chip-select width passed through to the PHY.

Ports, one per line (name, direction, width, meaning):
REQ-003 The block SHALL have clk_i, input, 1, the single clock.
REQ-004 The block SHALL have rst_ni, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have req_trans_valid_i / req_trans_ready_o, input / output, NumReq each, the per-requester transfer handshake.
REQ-006 The block SHALL have req_trans_i, input, NumReq x hyper_tf_t, the per-requester transfer descriptor.
REQ-007 The block SHALL have req_trans_cs_i, input, NumReq x NumChips, the per-requester chip select.
REQ-008 The block SHALL have req_tx_valid_i, req_tx_data_i, req_tx_strb_i and req_tx_last_i (inputs, NumReq x 1/16/2/1) and req_tx_ready_o (output, NumReq).
REQ-009 The block SHALL have req_rx_valid_o, req_rx_data_o, req_rx_error_o and req_rx_last_o (outputs, NumReq x 1/16/1/1) and req_rx_ready_i (input, NumReq).
REQ-010 The block SHALL have req_b_valid_o and req_b_error_o (outputs, NumReq) and req_b_ready_i (input, NumReq).
REQ-011 The block SHALL have phy_trans_valid_o / phy_trans_ready_i, phy_trans_o (hyper_tf_t) and phy_trans_cs_o (NumChips): the PHY transfer port.
REQ-012 The block SHALL have phy_tx_*, phy_rx_* and phy_b_* ports that mirror the single-requester channels, in the opposite direction.
REQ-013 The block SHALL have owner_o, output, IdxWidth = max(1, clog2(NumReq)): the index of the current owner.
REQ-014 The block SHALL have busy_o, output, 1: high when the block is not in Idle.

Function
REQ-015 The FSM SHALL have the states Idle, Offer and Busy.
REQ-016 In Idle with any req_trans_valid_i high, the block SHALL select by round-robin, starting the search at rr_ptr_q, and present the selected descriptor on phy_trans_o in the same cycle (zero latency).
REQ-017 If phy_trans_ready_i is high in that same cycle, the block SHALL pulse req_trans_ready_o[sel] and go to Busy with owner_q set to sel; otherwise it SHALL lock owner_q to sel and go to Offer.
REQ-018 In Offer, the block SHALL present only owner_q's descriptor; later requests, including higher-priority ones, SHALL NOT change the selection. On phy_trans_ready_i it SHALL go to Busy.
REQ-019 In Busy, the block SHALL route all tx/rx/b channels between owner_q and the PHY combinationally; non-owner outputs SHALL be 0 (valid/ready 0, data 0).
REQ-020 The block SHALL latch is_write from phy_trans_o.write at acceptance.
REQ-021 Completion SHALL be detected as follows:
- write: phy_b_valid_i & req_b_ready_i[owner_q]
- read: phy_rx_valid_i & phy_rx_last_i & req_rx_ready_i[owner_q]
REQ-022 On completion, the block SHALL go to Idle and set rr_ptr_q = owner_q + 1, wrapping from NumReq-1 to 0.
REQ-023 A new transfer SHALL be granted no earlier than the cycle after completion.
REQ-024 phy_trans_valid_o and all req_trans_ready_o SHALL be 0 in Busy.
REQ-025 A B response or rx beat arriving while in Idle or Offer SHALL be dropped, with phy ready held at 1, and sticky_err_q SET.
REQ-026 rr_ptr_q SHALL be IdxWidth bits wide; for non-power-of-two NumReq the wrap SHALL be an explicit comparison, not an overflow.
REQ-027 A requester deasserting valid in Offer is a protocol violation; the block SHALL still hold the lock until acceptance.

Reset
REQ-028 On reset, the block SHALL set: state Idle, owner_q 0, rr_ptr_q 0, is_write 0, sticky_err_q 0.
REQ-029 All outputs SHALL be 0 in reset.
REQ-030 A reset asserted mid-transfer SHALL abandon the transfer with no completion signalled; PHY reset is the caller's responsibility.

Structure
REQ-031 hyper_tf_t SHALL come from hyperbus_pkg.
REQ-032 The new typedef hyper_arb_state_t {Idle, Offer, Busy} SHALL be added to hyperbus_pkg.
REQ-033 The round-robin search SHALL be one sub-module, hyperbus_rr_sel: combinational, with inputs req mask and rr_ptr and outputs sel index and any-valid.
REQ-034 Channel muxing SHALL be inline.

Verification
REQ-035 Requests 0 and 1 arrive the same cycle, PHY ready -> req 0 granted; after its B handshake, req 1 is granted one cycle later; owner_o goes 0 then 1.
REQ-036 Req 1 valid, PHY not ready for 3 cycles, req 0 valid in cycle 2 -> phy_trans_o stays req 1's descriptor, and req 1 is accepted in cycle 4.
REQ-037 Owner 1 reads a burst of 4 with req_rx_ready_i[1] stalled 2 cycles -> 4 beats reach only req 1, and Idle follows the last beat's handshake.
REQ-038 Owner 0 writes 2 beats -> req_tx_ready_o[1] stays 0 throughout, and the B response goes only to req 0.
REQ-039 With NumReq=3, request all three continuously -> grant order 0,1,2,0.
REQ-040 Assert reset in Busy -> the next cycle shows Idle, rr_ptr 0, and all valids 0.
